// File: rtl/pulse_width_capture_if.sv
// Width result handshake between pulse_width_capture and its consumer
// (histogram write path).
//   count_out   : measured width, held stable while count_valid=1
//   count_valid : a width word is pending (drives wrreq)
//   count_ready : consumer accepts; transfer when count_valid && count_ready
// Modports: master = capture block (producer), slave = consumer.
interface pulse_width_capture_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] count_out;
  logic                  count_valid;
  logic                  count_ready;

  modport master (
    output count_out,
    output count_valid,
    input  count_ready
  );

  modport slave (
    input  count_out,
    input  count_valid,
    output count_ready
  );
endinterface

// File: rtl/pulse_width_capture.sv
// pulse_width_capture: measures the high time of each pulse on pulse_in in
// clk cycles and offers it as a DATA_WIDTH word on a valid/ready handshake.
// Keeps delivered-count, drop and saturation statistics for status readback.
//
// Ports:
//   clk             capture clock (fastest domain)
//   areset_n        synchronous active-low reset
//   enable          capture enable
//   clear_stats     one-cycle pulse, zeroes pulses_captured/drop_flag/sat_flag
//   pulse_in        asynchronous pulse input (synchronized internally)
//   result          handshake interface (master): count_out/count_valid/count_ready
//   busy            FSM is measuring a pulse
//   pulses_captured saturating count of delivered widths
//   drop_flag       sticky: a completed width was lost because the output was occupied
//   sat_flag        sticky: a width saturated at all-ones
//
// Optional feature: define PWC_MIN_FILTER_EN to discard completed widths
// shorter than MIN_WIDTH as glitches (no valid, no drop, no statistics).
module pulse_width_capture #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic                  enable,
  input  logic                  clear_stats,
  input  logic                  pulse_in,
  pulse_width_capture_if.master result,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] pulses_captured,
  output logic                  drop_flag,
  output logic                  sat_flag
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  // Elaboration-time legality checks.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("pulse_width_capture: SYNC_STAGES must be 2..4");
  end
  if (MIN_WIDTH < 1) begin : g_bad_min
    $error("pulse_width_capture: MIN_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    s;
  logic                    s_d;
  logic                    rise;
  logic                    fall;
  logic [DATA_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   count_q;
  logic                    valid_q;
  logic                    handshake;
  logic                    width_ok;
  logic                    out_free;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pulse_in};
      s_d  <= s;
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // ---------------------------------------------------------------------------
  // Handshake / width qualification
  // ---------------------------------------------------------------------------
  assign handshake = valid_q & result.count_ready;
  // Output register can take a new word if empty or being emptied this edge.
  assign out_free  = ~valid_q | result.count_ready;

`ifdef PWC_MIN_FILTER_EN
  localparam logic [DATA_WIDTH-1:0] MIN_W = DATA_WIDTH'(MIN_WIDTH);
  assign width_ok = (cnt >= MIN_W);
`else
  assign width_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // FSM, measurement counter, output register and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      cnt             <= '0;
      count_q         <= '0;
      valid_q         <= 1'b0;
      pulses_captured <= '0;
      drop_flag       <= 1'b0;
      sat_flag        <= 1'b0;
    end else begin
      // Handshake empties the output register; a reload below overrides it.
      if (handshake) begin
        valid_q <= 1'b0;
        if (pulses_captured != '1) begin
          pulses_captured <= pulses_captured + ONE;
        end
      end

      case (state)
        IDLE: begin
          // Waiting for s=0 guarantees a pulse already high is never measured.
          if (enable && !s) begin
            state <= ARMED;
          end
        end

        ARMED: begin
          if (!enable) begin
            state <= IDLE;
          end else if (rise) begin
            cnt   <= ONE;
            state <= MEASURE;
            busy  <= 1'b1;
          end
        end

        MEASURE: begin
          if (!enable) begin
            // Partial width discarded.
            state <= IDLE;
            busy  <= 1'b0;
          end else if (fall) begin
            state <= ARMED;
            busy  <= 1'b0;
            if (width_ok) begin
              if (out_free) begin
                count_q <= cnt;
                valid_q <= 1'b1;
              end else begin
                drop_flag <= 1'b1;
              end
            end
          end else if (s) begin
            if (cnt == '1) begin
              sat_flag <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Clear has priority over any same-cycle statistic update.
      if (clear_stats) begin
        pulses_captured <= '0;
        drop_flag       <= 1'b0;
        sat_flag        <= 1'b0;
      end
    end
  end

  assign result.count_out   = count_q;
  assign result.count_valid = valid_q;

endmodule
